// File: rtl/usb_tx_pkg.sv
// Shared types, CRC16 constants and the byte-wise CRC16 step for the USB transmit arbiter.
package usb_tx_pkg;

    // Arbiter state encoding; codes not listed here fall back to IDLE.
    typedef logic [1:0] usb_tx_state_t;

    localparam usb_tx_state_t ST_IDLE   = 2'd0;
    localparam usb_tx_state_t ST_DATA   = 2'd1;
    localparam usb_tx_state_t ST_CRC_LO = 2'd2;
    localparam usb_tx_state_t ST_CRC_HI = 2'd3;

    localparam logic [15:0] CRC16_POLY_R = 16'hA001;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    // Reflected CRC16: data enters LSB first, so the feedback bit is crc[0] ^ data[i].
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC16_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Registered USB CRC16 accumulator; clear has priority over en and reloads the init value.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_next(r_crc, i_byte);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_tx_arb.sv
// Round-robin USB transmit arbiter and packet sequencer.
// Define USB_TX_ARB_CRC_EN to append the 2-byte CRC16 after every packet.
module usb_tx_arb
    import usb_tx_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 8,
    localparam int unsigned GNT_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        i_src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]        i_src_last,
    output logic [NUM_SRC-1:0]        o_src_ready,
    output logic                      o_tx_valid,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_ready,
    output logic [GNT_W-1:0]          o_gnt_id,
    output logic                      o_busy,
    output logic                      o_pkt_done
);

    usb_tx_state_t     r_state;
    usb_tx_state_t     w_state_d;
    logic [GNT_W-1:0]  r_gnt_id;
    logic [GNT_W-1:0]  r_rr_ptr;
    logic              r_pkt_done;

    logic [GNT_W-1:0]  w_pick;
    logic              w_found;
    int unsigned       w_scan_idx;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_xfer;
    logic              w_done;
    logic              w_crc_en;

    // First requester at or after the round-robin pointer, scanning upward with wrap.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = r_rr_ptr;
        w_scan_idx = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = (int'(r_rr_ptr) + k) % NUM_SRC;
            if (!w_found && i_src_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_pick  = GNT_W'(w_scan_idx);
            end
        end
    end

    assign w_sel_valid = i_src_valid[r_gnt_id];
    assign w_sel_last  = i_src_last[r_gnt_id];
    assign w_sel_data  = i_src_data[r_gnt_id*DATA_W +: DATA_W];

`ifdef USB_TX_ARB_CRC_EN
    logic [15:0] w_crc;

    usb_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_done),
        .i_en    (w_crc_en),
        .i_byte  (w_sel_data[7:0]),
        .o_crc   (w_crc)
    );
`endif

    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_src_ready = '0;
        case (r_state)
            ST_DATA: begin
                o_tx_valid            = w_sel_valid;
                o_tx_data             = w_sel_data;
                o_src_ready[r_gnt_id] = i_tx_ready;
            end
`ifdef USB_TX_ARB_CRC_EN
            ST_CRC_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = DATA_W'(~w_crc[7:0]);
            end
            ST_CRC_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = DATA_W'(~w_crc[15:8]);
            end
`endif
            default: ;
        endcase
    end

    assign w_xfer = o_tx_valid & i_tx_ready;

    always_comb begin
        w_state_d = r_state;
        w_done    = 1'b0;
        w_crc_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_crc_en = 1'b1;
                    if (w_sel_last) begin
`ifdef USB_TX_ARB_CRC_EN
                        w_state_d = ST_CRC_LO;
`else
                        w_state_d = ST_IDLE;
                        w_done    = 1'b1;
`endif
                    end
                end
            end
`ifdef USB_TX_ARB_CRC_EN
            ST_CRC_LO: begin
                if (i_tx_ready) begin
                    w_state_d = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                if (i_tx_ready) begin
                    w_state_d = ST_IDLE;
                    w_done    = 1'b1;
                end
            end
`endif
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pkt_done <= w_done;
            if (r_state == ST_IDLE && w_found) begin
                r_gnt_id <= w_pick;
            end
            if (w_done) begin
                r_rr_ptr <= (r_gnt_id == GNT_W'(NUM_SRC - 1)) ? '0 : r_gnt_id + 1'b1;
            end
        end
    end

    assign o_gnt_id   = r_gnt_id;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_pkt_done = r_pkt_done;

endmodule

// File: tb/tb_usb_tx_arb.sv
// Directed self-checking bench for usb_tx_arb; expectations follow USB_TX_ARB_CRC_EN.
module tb_usb_tx_arb;

    localparam int NS = 4;
`ifdef USB_TX_ARB_CRC_EN
    localparam int EXTRA = 2;
    localparam int MID_BEATS = 9;
`else
    localparam int EXTRA = 0;
    localparam int MID_BEATS = 5;
`endif

    logic          clk;
    logic          reset;
    logic [NS-1:0] src_valid;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0] src_last;
    logic [NS-1:0] src_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic [1:0]    gnt_id;
    logic          busy;
    logic          pkt_done;

    usb_tx_arb #(.NUM_SRC(NS), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_src_valid (src_valid),
        .i_src_data  (src_data),
        .i_src_last  (src_last),
        .o_src_ready (src_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_gnt_id    (gnt_id),
        .o_busy      (busy),
        .o_pkt_done  (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Source model: each source replays its packet s_reps times.
    logic [7:0] s_mem [NS][16];
    int s_len [NS];
    int s_pos [NS];
    int s_reps [NS];
    logic [NS-1:0] s_en;
    logic rdy_mode;

    logic [7:0] b_data [$];
    int b_gnt [$];
    int b_cyc [$];
    int done_cyc [$];
    logic [7:0] exp_q [$];
    int sr_bad;
    int rdy_cnt;

    logic ob_tx_valid, ob_busy, ob_pkt_done;
    logic [1:0] ob_gnt;
    logic [NS-1:0] ob_src_ready;

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = s_en[i] && (s_reps[i] > 0);
            src_data[i*8 +: 8] = s_mem[i][s_pos[i]];
            src_last[i] = (s_pos[i] == s_len[i] - 1);
        end
    endtask

    task automatic cycle();
        logic [NS-1:0] v_ready, v_valid;
        drive_srcs();
        tx_ready = rdy_mode ? ~cyc[0] : 1'b1;
        #2;
        v_ready = src_ready;
        v_valid = src_valid;
        ob_tx_valid = tx_valid;
        ob_busy = busy;
        ob_gnt = gnt_id;
        ob_pkt_done = pkt_done;
        ob_src_ready = src_ready;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            b_data.push_back(tx_data);
            b_gnt.push_back(int'(gnt_id));
            b_cyc.push_back(cyc);
        end
        if (pkt_done === 1'b1) done_cyc.push_back(cyc);
        if ((v_ready & ~{NS{tx_ready}}) != 0 || !$onehot0(v_ready)) sr_bad++;
        rdy_cnt += $countones(v_ready & v_valid);
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (v_ready[i] && v_valid[i]) begin
                s_pos[i]++;
                if (s_pos[i] >= s_len[i]) begin
                    s_pos[i] = 0;
                    s_reps[i]--;
                end
            end
        end
        cyc++;
    endtask

    task automatic clear_srcs();
        s_en = '0;
        rdy_mode = 1'b0;
        for (int i = 0; i < NS; i++) begin
            s_len[i] = 0;
            s_pos[i] = 0;
            s_reps[i] = 0;
        end
    endtask

    task automatic clear_logs();
        b_data.delete();
        b_gnt.delete();
        b_cyc.delete();
        done_cyc.delete();
        exp_q.delete();
        sr_bad = 0;
        rdy_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_srcs();
        cycle();
        cycle();
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic load(input int i, input string s, input int reps);
        for (int k = 0; k < s.len(); k++) s_mem[i][k] = s[k];
        s_len[i] = s.len();
        s_pos[i] = 0;
        s_reps[i] = reps;
        s_en[i] = 1'b1;
    endtask

    // Independent CRC16/USB model: byte folded into the low bits, then 8 reflected shifts.
    function automatic logic [15:0] tb_crc(input int i);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < s_len[i]; k++) begin
            c = c ^ {8'h00, s_mem[i][k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_pkt(input int i);
        logic [15:0] c;
        for (int k = 0; k < s_len[i]; k++) exp_q.push_back(s_mem[i][k]);
        c = tb_crc(i);
        if (EXTRA == 2) begin
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_srcs();
        load(0, "ab", 1);
        load(2, "cd", 1);
        cycle();
        cycle();
        checks++;
        if (ob_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", ob_tx_valid); end
        checks++;
        if (ob_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ob_busy); end
        checks++;
        if (ob_gnt !== 2'd0) begin failures++; $display("FAIL reset_gnt_id: got %0d expected 0", ob_gnt); end
        checks++;
        if (ob_pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done: got %b expected 0", ob_pkt_done); end
        checks++;
        if (ob_src_ready !== 4'b0000) begin failures++; $display("FAIL reset_src_ready: got %b expected 0000", ob_src_ready); end
        reset = 1'b1;
        clear_srcs();
        clear_logs();
    endtask

    task automatic test_crc_vector();
        int start;
        do_reset();
        load(1, "123456789", 1);
        start = cyc;
        repeat (24) cycle();
        for (int k = 0; k < 9; k++) exp_q.push_back(8'h31 + 8'(k));
`ifdef USB_TX_ARB_CRC_EN
        exp_q.push_back(8'hC8);
        exp_q.push_back(8'hB4);
`endif
        checks++;
        if (b_data.size() != exp_q.size()) begin failures++; $display("FAIL vec_beats: got %0d expected %0d", b_data.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL vec_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        foreach (b_gnt[k]) begin
            checks++;
            if (b_gnt[k] != 1) begin failures++; $display("FAIL vec_gnt%0d: got %0d expected 1", k, b_gnt[k]); end
        end
        checks++;
        if (done_cyc.size() != 1) begin failures++; $display("FAIL vec_done_cnt: got %0d expected 1", done_cyc.size()); end
        if (b_cyc.size() > 0 && done_cyc.size() > 0) begin
            checks++;
            if (done_cyc[0] != b_cyc[b_cyc.size()-1] + 1) begin
                failures++; $display("FAIL vec_done_cyc: got %0d expected %0d", done_cyc[0], b_cyc[b_cyc.size()-1] + 1);
            end
            checks++;
            if (b_cyc[0] != start + 1) begin failures++; $display("FAIL vec_latency: got %0d expected %0d", b_cyc[0], start + 1); end
        end
    endtask

    task automatic test_round_robin();
        int p;
        p = 2 + EXTRA;
        do_reset();
        load(0, "ab", 2);
        load(2, "cd", 1);
        load(3, "ef", 1);
        repeat (40) cycle();
        push_pkt(0);
        push_pkt(2);
        push_pkt(3);
        push_pkt(0);
        checks++;
        if (b_data.size() != exp_q.size()) begin failures++; $display("FAIL rr_beats: got %0d expected %0d", b_data.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL rr_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        for (int n = 0; n < 4; n++) if (n * p < b_gnt.size()) begin
            checks++;
            if (b_gnt[n*p] != ((n == 0 || n == 3) ? 0 : n + 1)) begin
                failures++; $display("FAIL rr_order%0d: got %0d expected %0d", n, b_gnt[n*p], (n == 0 || n == 3) ? 0 : n + 1);
            end
        end
        for (int n = 0; n < 3; n++) if ((n + 1) * p < b_cyc.size()) begin
            checks++;
            if (b_cyc[(n+1)*p] - b_cyc[n*p + p - 1] != 2) begin
                failures++; $display("FAIL rr_gap%0d: got %0d expected 2", n, b_cyc[(n+1)*p] - b_cyc[n*p + p - 1]);
            end
        end
        checks++;
        if (done_cyc.size() != 4) begin failures++; $display("FAIL rr_done_cnt: got %0d expected 4", done_cyc.size()); end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        rdy_mode = 1'b1;
        load(1, "123456789", 1);
        repeat (40) cycle();
        push_pkt(1);
        checks++;
        if (b_data.size() != exp_q.size()) begin failures++; $display("FAIL tog_beats: got %0d expected %0d", b_data.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL tog_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        checks++;
        if (sr_bad != 0) begin failures++; $display("FAIL tog_src_ready: got %0d bad cycles expected 0", sr_bad); end
        checks++;
        if (rdy_cnt != 9) begin failures++; $display("FAIL tog_accepts: got %0d expected 9", rdy_cnt); end
        checks++;
        if (done_cyc.size() != 1) begin failures++; $display("FAIL tog_done_cnt: got %0d expected 1", done_cyc.size()); end
    endtask

    task automatic test_drop_valid();
        do_reset();
        load(2, "WXYZ", 1);
        load(0, "pq", 1);
        s_en[0] = 1'b0;
        for (int t = 0; t < 20 && b_data.size() < 2; t++) cycle();
        s_en[2] = 1'b0;
        s_en[0] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cycle();
            checks++;
            if (ob_tx_valid !== 1'b0) begin failures++; $display("FAIL drop_tx_valid%0d: got %b expected 0", t, ob_tx_valid); end
            checks++;
            if (ob_gnt !== 2'd2) begin failures++; $display("FAIL drop_gnt%0d: got %0d expected 2", t, ob_gnt); end
        end
        s_en[2] = 1'b1;
        repeat (30) cycle();
        push_pkt(2);
        push_pkt(0);
        checks++;
        if (b_data.size() != exp_q.size()) begin failures++; $display("FAIL drop_beats: got %0d expected %0d", b_data.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL drop_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        if (b_gnt.size() > 4 + EXTRA) begin
            checks++;
            if (b_gnt[4+EXTRA] != 0) begin failures++; $display("FAIL drop_next_gnt: got %0d expected 0", b_gnt[4+EXTRA]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(1, "123456789", 2);
        for (int t = 0; t < 80 && b_data.size() < 9 + EXTRA + MID_BEATS; t++) cycle();
        checks++;
        if (b_data.size() != 9 + EXTRA + MID_BEATS) begin
            failures++; $display("FAIL mid_reach: got %0d expected %0d", b_data.size(), 9 + EXTRA + MID_BEATS);
        end
        checks++;
        if (ob_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b expected 1", ob_busy); end
        reset = 1'b0;
        clear_srcs();
        cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (ob_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_tx_valid: got %b expected 0", ob_tx_valid); end
        checks++;
        if (ob_busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", ob_busy); end
        clear_logs();
        load(0, "123456789", 1);
        load(3, "xy", 1);
        repeat (40) cycle();
        push_pkt(0);
        push_pkt(3);
        checks++;
        if (b_data.size() != exp_q.size()) begin failures++; $display("FAIL mid_beats: got %0d expected %0d", b_data.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL mid_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        if (b_gnt.size() > 0) begin
            checks++;
            if (b_gnt[0] != 0) begin failures++; $display("FAIL mid_rr_ptr: got gnt %0d expected 0", b_gnt[0]); end
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        s_mem[0][0] = 8'hA5;
        s_len[0] = 1;
        s_pos[0] = 0;
        s_reps[0] = 1;
        s_en[0] = 1'b1;
        repeat (10) cycle();
        push_pkt(0);
        checks++;
        if (b_data.size() != 1 + EXTRA) begin failures++; $display("FAIL one_beats: got %0d expected %0d", b_data.size(), 1 + EXTRA); end
        foreach (exp_q[k]) if (k < b_data.size()) begin
            checks++;
            if (b_data[k] !== exp_q[k]) begin failures++; $display("FAIL one_byte%0d: got %h expected %h", k, b_data[k], exp_q[k]); end
        end
        checks++;
        if (done_cyc.size() != 1) begin failures++; $display("FAIL one_done_cnt: got %0d expected 1", done_cyc.size()); end
        if (b_cyc.size() > 0 && done_cyc.size() > 0) begin
            checks++;
            if (done_cyc[0] != b_cyc[b_cyc.size()-1] + 1) begin
                failures++; $display("FAIL one_done_cyc: got %0d expected %0d", done_cyc[0], b_cyc[b_cyc.size()-1] + 1);
            end
        end
        checks++;
        if (ob_busy !== 1'b0) begin failures++; $display("FAIL one_idle: got busy %b expected 0", ob_busy); end
    endtask

    initial begin
        reset = 1'b0;
        tx_ready = 1'b1;
        src_valid = '0;
        src_data = '0;
        src_last = '0;
        for (int i = 0; i < NS; i++) for (int k = 0; k < 16; k++) s_mem[i][k] = 8'h00;
        clear_srcs();
        clear_logs();
        test_reset();
        test_crc_vector();
        test_round_robin();
        test_ready_toggle();
        test_drop_valid();
        test_reset_mid();
        test_single_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
